acc_frame_arbiter: RTL and testbench
====================================

Name: acc_frame_arbiter

Overview:
Shares one acc instance (running-sum accumulator, A operand in, Sum running total out) between NREQ requesters. Grants the accumulator to one requester for a whole frame of FRAME_LEN operands, chosen round-robin. Sequences the operands through acc and derives the per-frame sum from acc's never-cleared running total. Returns the frame sum tagged with the requester id. Sits on the RTL side of the channel wrappers, between the hamming partial-distance sources and the shared acc.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 16, operand/sum width; must equal acc WIDTH
FRAME_LEN, 8, operands per granted frame (1..255)

Ports:
CLK  in  1  clock
_RESET  in  1  asynchronous, active-low reset
in_valid  in  NREQ  per-requester operand valid
in_data  in  NREQ*WIDTH  per-requester operand, requester i at [i*WIDTH +: WIDTH]
in_ready  out  NREQ  per-requester operand accept
acc_a_valid  out  1  operand to acc A channel
acc_a_data  out  WIDTH  operand to acc
acc_a_ready  in  1  acc accepts A
acc_sum_valid  in  1  acc Sum channel valid
acc_sum_data  in  WIDTH  acc running total
acc_sum_ready  out  1  accept Sum
out_valid  out  1  frame result valid
out_data  out  WIDTH  frame sum mod 2^WIDTH
out_id  out  $clog2(NREQ)  requester owning result
out_ready  in  1  consumer accepts result

Behaviour:
- Handshake on all channels: transfer when valid & ready are high on the same CLK edge. Valid is held with stable data until the transfer.
- Reset values: in_ready=0, acc_a_valid=0, acc_sum_ready=0, out_valid=0, out_data=0, out_id=0, state=IDLE, rr_ptr=0, base=0, cnt=0.
- base mirrors acc's reset value of 0. Both blocks share _RESET, so a reset mid-frame discards the frame and both restart at 0.
- FSM states:
  - IDLE: if any in_valid, grant g = first requester with in_valid, searching from rr_ptr upward with wrap. Register g, cnt=0, go to SEND_A next cycle. Otherwise stay in IDLE.
  - SEND_A: acc_a_valid = in_valid[g]; acc_a_data = in_data[g]; in_ready[g] = acc_a_ready; all other in_ready = 0. On transfer go to WAIT_SUM.
  - WAIT_SUM: acc_sum_ready = 1. On transfer, last = acc_sum_data and cnt = cnt+1. If cnt+1 == FRAME_LEN, go to EMIT; otherwise go to SEND_A.
  - EMIT: out_valid = 1; out_data = last - base (modular WIDTH subtraction; wrap-around is correct by construction); out_id = g. On transfer, base = last, rr_ptr = (g+1) mod NREQ, go to IDLE.
- Exactly one operand is outstanding in acc at any time, because acc emits one Sum per A.
- Minimum frame latency is 2*FRAME_LEN+2 cycles from grant to out_valid, with zero-wait peers.
- Non-granted requesters are stalled (in_ready=0) for the whole frame. A granted requester dropping in_valid mid-frame stalls the frame; there is no re-arbitration.
- Simultaneous requests: lowest index at or after rr_ptr wins.
- out_ready low holds EMIT indefinitely, and no new grant is made while in EMIT.

Optional Feature:
Macro: ACC_ARB_TIMEOUT_EN.
- With the macro defined:
  - Adds parameter TIMEOUT (default 64) and output port out_err (1 bit, reset 0).
  - In SEND_A, a counter increments on every cycle in_valid[g] is 0, and resets on transfer.
  - On reaching TIMEOUT, the frame is ended early: go to EMIT with out_data = last - base (0 if cnt==0) and out_err = 1.
  - out_err is 0 on normal frames.
- Without the macro: SEND_A waits forever; no out_err port and no counter logic.

Decomposition:
- Package acc_arb_pkg holds:
  - state_t enum {IDLE, SEND_A, WAIT_SUM, EMIT}
  - function rr_pick(req, ptr)
  - localparam ID_W = $clog2(NREQ)
- One natural sub-module: acc_rr_arbiter (combinational round-robin pick from in_valid and rr_ptr, outputs grant index and any_req).
- The FSM, counters, base/last registers and muxes stay in acc_frame_arbiter.

Test Plan:
- FRAME_LEN=4, single requester 2 sends 1,2,3,4 → acc sees A=1,2,3,4; out_data=10, out_id=2; base becomes 10.
- Requester 0 frame 5,5,5,5 then requester 0 frame 1,1,1,1 → out_data 20 then 4 (base subtraction verified, acc never cleared).
- All four in_valid high constantly → grants 0,1,2,3,0 in order; non-granted in_ready stay 0 throughout each frame.
- base=0xFFF0, frame 0x10,0x10,0x0,0x0 (acc total wraps to 0x0010) → out_data=0x0020.
- out_ready held low 10 cycles in EMIT → out_valid/out_data/out_id stable, no acc_a_valid, and no in_ready pulse on any requester.
- _RESET pulsed low mid-WAIT_SUM → all outputs return to reset values; next frame 1,1,1,1 gives out_data=4. With ACC_ARB_TIMEOUT_EN and TIMEOUT=8: requester sends 2 operands (3,4) then idles → out_err=1, out_data=7 after 8 idle cycles.

Source files
------------

// File: rtl/acc_arb_pkg.sv
// Shared types and the round-robin pick helper for the acc frame arbiter.
// The ACC_ARB_TIMEOUT_EN build option is handled in acc_frame_arbiter.
package acc_arb_pkg;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned ID_W     = $clog2(NREQ_DEF);
    localparam int unsigned PICK_W   = $clog2(NREQ_MAX);

    typedef enum logic [1:0] {IDLE, SEND_A, WAIT_SUM, EMIT} state_t;

    typedef struct packed {
        logic              any;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, wrapping within nreq entries.
    function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                      input logic [PICK_W-1:0]   ptr,
                                      input int unsigned         nreq);
        pick_t       p;
        int unsigned j;
        p = '0;
        for (int unsigned i = 0; i < NREQ_MAX; i++) begin
            j = 32'(ptr) + i;
            if (j >= nreq) j = j - nreq;
            if (i < nreq && !p.any && req[j[PICK_W-1:0]]) begin
                p.any = 1'b1;
                p.idx = PICK_W'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/acc_rr_arbiter.sv
// Combinational round-robin requester pick starting at ptr.
module acc_rr_arbiter
    import acc_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [$clog2(NREQ)-1:0] grant,
    output logic                    any_req
);

    localparam int unsigned IW = $clog2(NREQ);

    pick_t pick;

    assign pick    = rr_pick(NREQ_MAX'(req), PICK_W'(ptr), NREQ);
    assign grant   = IW'(pick.idx);
    assign any_req = pick.any;

endmodule

// File: rtl/acc_frame_arbiter.sv
// Grants the shared running-sum accumulator to one requester per frame and
// returns the frame sum. Optional stall timeout: define ACC_ARB_TIMEOUT_EN.
module acc_frame_arbiter
    import acc_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRAME_LEN = 8
`ifdef ACC_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = 64
`endif
) (
    input  logic                    CLK,
    input  logic                    _RESET,
    input  logic [NREQ-1:0]         in_valid,
    input  logic [NREQ*WIDTH-1:0]   in_data,
    output logic [NREQ-1:0]         in_ready,
    output logic                    acc_a_valid,
    output logic [WIDTH-1:0]        acc_a_data,
    input  logic                    acc_a_ready,
    input  logic                    acc_sum_valid,
    input  logic [WIDTH-1:0]        acc_sum_data,
    output logic                    acc_sum_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(NREQ)-1:0] out_id,
    input  logic                    out_ready
`ifdef ACC_ARB_TIMEOUT_EN
    ,
    output logic                    out_err
`endif
);

    localparam int unsigned IW    = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    state_t             state_q, state_d;
    logic [IW-1:0]      g_q, g_d, rr_q, rr_d, pick_g;
    logic               pick_any;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   last_q, last_d, base_q, base_d, odata_q, odata_d;
    logic               ovalid_q, ovalid_d, srdy_q, srdy_d;
`ifdef ACC_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    to_q, to_d;
    logic               err_q, err_d;
    assign out_err = err_q;
`endif

    acc_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (in_valid),
        .ptr     (rr_q),
        .grant   (pick_g),
        .any_req (pick_any)
    );

    assign out_valid     = ovalid_q;
    assign out_data      = odata_q;
    assign out_id        = g_q;
    assign acc_sum_ready = srdy_q;

    // State and datapath registers
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q  <= IDLE;
            g_q      <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
            base_q   <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            srdy_q   <= 1'b0;
`ifdef ACC_ARB_TIMEOUT_EN
            to_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            base_q   <= base_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            srdy_q   <= srdy_d;
`ifdef ACC_ARB_TIMEOUT_EN
            to_q     <= to_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state and channel muxing
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        base_d      = base_q;
        odata_d     = odata_q;
        in_ready    = '0;
        acc_a_valid = 1'b0;
        acc_a_data  = in_data[32'(g_q) * WIDTH +: WIDTH];
`ifdef ACC_ARB_TIMEOUT_EN
        to_d        = '0;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    g_d     = pick_g;
                    cnt_d   = '0;
                    state_d = SEND_A;
                end
            end
            SEND_A: begin
                acc_a_valid   = in_valid[g_q];
                in_ready[g_q] = acc_a_ready;
                if (in_valid[g_q] && acc_a_ready) begin
                    state_d = WAIT_SUM;
                end
`ifdef ACC_ARB_TIMEOUT_EN
                else if (!in_valid[g_q]) begin
                    // A silent owner ends its frame early with what has summed so far
                    if (to_q == TO_W'(TIMEOUT - 1)) begin
                        state_d = EMIT;
                        odata_d = (cnt_q == '0) ? '0 : last_q - base_q;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end else begin
                    to_d = to_q;
                end
`endif
            end
            WAIT_SUM: begin
                if (acc_sum_valid) begin
                    last_d = acc_sum_data;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(FRAME_LEN)) begin
                        state_d = EMIT;
                        odata_d = acc_sum_data - base_q;
`ifdef ACC_ARB_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end else begin
                        state_d = SEND_A;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    // acc is never cleared, so the next frame is measured from here
                    base_d  = last_q;
                    rr_d    = (32'(g_q) == NREQ - 1) ? '0 : g_q + IW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ovalid_d = (state_d == EMIT);
        srdy_d   = (state_d == WAIT_SUM);
    end

endmodule

// File: tb/tb_acc_frame_arbiter.sv
// Scoreboard bench for acc_frame_arbiter with a behavioural running-sum acc
// peer; the timeout case runs only when ACC_ARB_TIMEOUT_EN is defined.
module tb_acc_frame_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned FL = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] d;
    } a_exp_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] d;
        logic        err;
    } o_exp_t;

    logic                        CLK = 1'b0;
    logic                        _RESET = 1'b1;
    logic [NR-1:0]               in_valid;
    logic [NR*W-1:0]             in_data;
    logic [NR-1:0]               in_ready;
    logic                        acc_a_valid;
    logic [W-1:0]                acc_a_data;
    logic                        acc_a_ready;
    logic                        acc_sum_valid;
    logic [W-1:0]                acc_sum_data;
    logic                        acc_sum_ready;
    logic                        out_valid;
    logic [W-1:0]                out_data;
    logic [acc_arb_pkg::ID_W-1:0] out_id;
    logic                        out_ready = 1'b1;
`ifdef ACC_ARB_TIMEOUT_EN
    logic                        out_err;
`endif

    a_exp_t      exp_a[$];
    o_exp_t      exp_o[$];
    logic [15:0] rq[NR][$];
    int          n_run = 0;
    int          n_fail = 0;
    int          to_req = 0;
    int          to_seen = 0;
    string       to_name = "";
    logic        chk_rst = 1'b0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic [1:0]  hold_id = '0;
    logic [15:0] total = '0;
    logic        pending = 1'b0;

    always #5 CLK = ~CLK;

    acc_frame_arbiter #(
        .NREQ(NR), .WIDTH(W), .FRAME_LEN(FL)
`ifdef ACC_ARB_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .CLK           (CLK),
        ._RESET        (_RESET),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .acc_a_valid   (acc_a_valid),
        .acc_a_data    (acc_a_data),
        .acc_a_ready   (acc_a_ready),
        .acc_sum_valid (acc_sum_valid),
        .acc_sum_data  (acc_sum_data),
        .acc_sum_ready (acc_sum_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_id        (out_id),
        .out_ready     (out_ready)
`ifdef ACC_ARB_TIMEOUT_EN
        , .out_err     (out_err)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Requester and acc peer models: sample handshakes at negedge, update after posedge
    initial begin : driver
        logic [NR-1:0] fire;
        logic          a_f, s_f;
        logic [15:0]   a_d;
        in_valid      = '0;
        in_data       = '0;
        acc_a_ready   = 1'b1;
        acc_sum_valid = 1'b0;
        acc_sum_data  = '0;
        forever begin
            @(negedge CLK);
            fire = in_valid & in_ready;
            a_f  = acc_a_valid & acc_a_ready;
            a_d  = acc_a_data;
            s_f  = acc_sum_valid & acc_sum_ready;
            @(posedge CLK);
            #1;
            if (!_RESET) begin
                total   = '0;
                pending = 1'b0;
            end else begin
                if (s_f) pending = 1'b0;
                if (a_f) begin
                    total   = total + a_d;
                    pending = 1'b1;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (fire[i] && rq[i].size() != 0) rq[i].delete(0);
                in_valid[i] = (rq[i].size() != 0);
                in_data[i*W +: W] = (rq[i].size() != 0) ? rq[i][0] : 16'h0;
            end
            acc_a_ready   = !pending;
            acc_sum_valid = pending;
            acc_sum_data  = total;
        end
    end

    // Monitor: pops the scoreboard on every DUT transfer
    always @(negedge CLK) begin
        a_exp_t     ea;
        o_exp_t     eo;
        logic [3:0] oh;
        if (chk_rst) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_acc_a_valid", 32'(acc_a_valid), 32'd0);
            chk("rst_acc_sum_ready", 32'(acc_sum_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_out_id", 32'(out_id), 32'd0);
`ifdef ACC_ARB_TIMEOUT_EN
            chk("rst_out_err", 32'(out_err), 32'd0);
`endif
        end
        if (to_req != to_seen) begin
            n_run++;
            n_fail++;
            $display("FAIL wait_%s: no completion within cycle budget", to_name);
            to_seen = to_req;
        end
        if (hold_v) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(hold_d));
            chk("hold_id", 32'(out_id), 32'(hold_id));
        end
        hold_v  = out_valid && !out_ready;
        hold_d  = out_data;
        hold_id = out_id;
        if (out_valid) begin
            chk("emit_in_ready", 32'(in_ready), 32'd0);
            chk("emit_acc_a_valid", 32'(acc_a_valid), 32'd0);
        end
        if (acc_a_valid && acc_a_ready) begin
            if (exp_a.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL a_unexpected: got A=0x%0h, expected no operand", acc_a_data);
            end else begin
                ea = exp_a.pop_front();
                oh = 4'b0001 << ea.id;
                chk("a_data", 32'(acc_a_data), 32'(ea.d));
                chk("a_grant", 32'(in_ready), 32'(oh));
            end
        end
        if (out_valid && out_ready) begin
            if (exp_o.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL out_unexpected: got data=0x%0h id=%0d, expected none", out_data, out_id);
            end else begin
                eo = exp_o.pop_front();
                chk("out_data", 32'(out_data), 32'(eo.d));
                chk("out_id", 32'(out_id), 32'(eo.id));
`ifdef ACC_ARB_TIMEOUT_EN
                chk("out_err", 32'(out_err), 32'(eo.err));
`endif
            end
        end
    end

    task automatic push_op(input int r, input logic [15:0] d);
        a_exp_t e;
        e.id = 2'(r);
        e.d  = d;
        rq[r].push_back(d);
        exp_a.push_back(e);
    endtask

    task automatic expect_out(input int r, input logic [15:0] s, input logic err);
        o_exp_t e;
        e.id  = 2'(r);
        e.d   = s;
        e.err = err;
        exp_o.push_back(e);
    endtask

    task automatic push_frame(input int r, input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3,
                              input logic [15:0] s);
        push_op(r, a0);
        push_op(r, a1);
        push_op(r, a2);
        push_op(r, a3);
        expect_out(r, s, 1'b0);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_a.size() != 0 || exp_o.size() != 0) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (exp_a.size() != 0 || exp_o.size() != 0) begin
            to_name = nm;
            to_req++;
            exp_a.delete();
            exp_o.delete();
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin : stim
        int n;
        chk_rst = 1'b1;
        #1 _RESET = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk_rst = 1'b0;
        _RESET  = 1'b1;

        // All requesters valid at once: grants 0,1,2,3 then 0 again
        push_frame(0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd4);
        push_frame(1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd8);
        push_frame(2, 16'd3, 16'd3, 16'd3, 16'd3, 16'd12);
        push_frame(3, 16'd4, 16'd4, 16'd4, 16'd4, 16'd16);
        push_frame(0, 16'd5, 16'd5, 16'd5, 16'd5, 16'd20);
        drain("rr_all");

        // Single requester 2, acc total now 70
        push_frame(2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd10);
        drain("single_req2");

        // Back-to-back frames from requester 0, acc total now 94
        push_frame(0, 16'd5, 16'd5, 16'd5, 16'd5, 16'd20);
        push_frame(0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd4);
        drain("base_sub");

        // Bring base to 0xFFF0 (94 + 0xFF92), then a frame that wraps acc to 0x0010
        push_frame(1, 16'hFF92, 16'h0, 16'h0, 16'h0, 16'hFF92);
        drain("to_fff0");
        push_frame(3, 16'h0010, 16'h0010, 16'h0, 16'h0, 16'h0020);
        drain("wrap");

        // Consumer stall in EMIT with another requester waiting
        out_ready = 1'b0;
        push_frame(1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd10);
        push_frame(2, 16'd7, 16'd7, 16'd7, 16'd7, 16'd28);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!out_valid) begin
            to_name = "emit_hold";
            to_req++;
        end
        repeat (10) @(negedge CLK);
        @(posedge CLK);
        #1 out_ready = 1'b1;
        drain("emit_release");

        // Reset while waiting for a Sum, then a clean frame from zero
        push_frame(3, 16'd1, 16'd1, 16'd1, 16'd1, 16'd4);
        n = 0;
        while (!acc_sum_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!acc_sum_ready) begin
            to_name = "wait_sum";
            to_req++;
        end
        #1;
        _RESET = 1'b0;
        rq[3].delete();
        exp_a.delete();
        exp_o.delete();
        chk_rst = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        chk_rst = 1'b0;
        _RESET  = 1'b1;
        push_frame(3, 16'd1, 16'd1, 16'd1, 16'd1, 16'd4);
        drain("after_reset");

`ifdef ACC_ARB_TIMEOUT_EN
        // Owner goes silent after two operands: 3+4 reported with the error flag
        push_op(0, 16'd3);
        push_op(0, 16'd4);
        expect_out(0, 16'd7, 1'b1);
        drain("timeout");
`endif

        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
